// File: rtl/video_mem_sequencer.sv
// Pixel-clock SRAM sequencer: eight-slot character period shared by video RAM/ROM fetches and one CPU access.
// Optional macro CHAR_ROM_WP_EN blocks CPU writes into the character ROM window (the access is still acked).
module video_mem_sequencer #(
    parameter logic [16:0] VRAM_BASE  = 17'h08000,
    parameter logic [16:0] CHROM_BASE = 17'h10000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        char_clk,
    input  logic [11:0] video_addr,
    output logic [7:0]  video_data,
    output logic        video_ram_strobe,
    output logic        video_rom_strobe,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_oe,
    output logic        mem_we
);

    typedef enum logic [2:0] {
        PH_VRAM_ADDR = 3'd0,
        PH_VRAM_DATA = 3'd1,
        PH_VRAM_IDLE = 3'd2,
        PH_ROM_ADDR  = 3'd3,
        PH_ROM_DATA  = 3'd4,
        PH_ROM_IDLE  = 3'd5,
        PH_CPU_ACC   = 3'd6,
        PH_CPU_DONE  = 3'd7
    } phase_t;

    phase_t      r_phase, w_phase_n;
    logic [1:0]  r_rst_sync;
    logic        r_started, w_started_n;
    logic        r_pending, w_pending_n;
    logic        r_cpu_act, w_cpu_act_n;
    logic [7:0]  r_video_data, w_video_data_n;
    logic        r_ram_stb, w_ram_stb_n;
    logic        r_rom_stb, w_rom_stb_n;
    logic [7:0]  r_cpu_dout, w_cpu_dout_n;
    logic        r_cpu_ack, w_cpu_ack_n;
    logic [16:0] r_mem_addr, w_mem_addr_n;
    logic [7:0]  r_mem_dout, w_mem_dout_n;
    logic        r_mem_oe, w_mem_oe_n;
    logic        r_mem_we, w_mem_we_n;
    logic        w_wp;

    function automatic logic [16:0] map_addr(input logic [11:0] a);
        map_addr = (a[11] ? CHROM_BASE : VRAM_BASE) + {6'd0, a[10:0]};
    endfunction

`ifdef CHAR_ROM_WP_EN
    assign w_wp = (cpu_addr >= CHROM_BASE) && (cpu_addr <= CHROM_BASE + 17'h007FF);
`else
    assign w_wp = 1'b0;
`endif

    // Reset asserts asynchronously but releases two edges later, in step with clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    always_comb begin
        w_phase_n      = (!r_started || char_clk) ? PH_VRAM_ADDR : phase_t'(r_phase + 3'd1);
        w_started_n    = r_rst_sync[1];
        w_pending_n    = r_pending | (cpu_req & ~r_pending & ~r_cpu_ack);
        w_cpu_act_n    = 1'b0;
        w_video_data_n = r_video_data;
        w_ram_stb_n    = 1'b0;
        w_rom_stb_n    = 1'b0;
        w_cpu_dout_n   = r_cpu_dout;
        w_cpu_ack_n    = 1'b0;
        w_mem_addr_n   = r_mem_addr;
        w_mem_dout_n   = r_mem_dout;
        w_mem_oe_n     = 1'b0;
        w_mem_we_n     = 1'b0;

        // Outputs are registered for the phase being entered, so decode on the next phase.
        case (w_phase_n)
            PH_VRAM_ADDR, PH_ROM_ADDR: begin
                w_mem_addr_n = map_addr(video_addr);
                w_mem_oe_n   = 1'b1;
            end
            PH_VRAM_DATA: begin
                w_video_data_n = mem_din;
                w_ram_stb_n    = 1'b1;
                w_mem_oe_n     = 1'b1;
            end
            PH_ROM_DATA: begin
                w_video_data_n = mem_din;
                w_rom_stb_n    = 1'b1;
                w_mem_oe_n     = 1'b1;
            end
            PH_CPU_ACC: begin
                if (w_pending_n) begin
                    w_cpu_act_n  = 1'b1;
                    w_mem_addr_n = cpu_addr;
                    w_mem_dout_n = cpu_din;
                    w_mem_we_n   = cpu_we & ~w_wp;
                    w_mem_oe_n   = ~cpu_we;
                end
            end
            PH_CPU_DONE: begin
                // Reached only straight from the CPU slot; a resync there skips this ack.
                if (r_cpu_act) begin
                    w_cpu_ack_n = 1'b1;
                    w_pending_n = 1'b0;
                    if (!cpu_we) w_cpu_dout_n = mem_din;
                end
            end
            default: ;
        endcase

        if (!r_rst_sync[1]) begin
            w_phase_n      = PH_VRAM_ADDR;
            w_pending_n    = 1'b0;
            w_cpu_act_n    = 1'b0;
            w_video_data_n = 8'd0;
            w_ram_stb_n    = 1'b0;
            w_rom_stb_n    = 1'b0;
            w_cpu_dout_n   = 8'd0;
            w_cpu_ack_n    = 1'b0;
            w_mem_addr_n   = 17'd0;
            w_mem_dout_n   = 8'd0;
            w_mem_oe_n     = 1'b0;
            w_mem_we_n     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase      <= PH_VRAM_ADDR;
            r_started    <= 1'b0;
            r_pending    <= 1'b0;
            r_cpu_act    <= 1'b0;
            r_video_data <= 8'd0;
            r_ram_stb    <= 1'b0;
            r_rom_stb    <= 1'b0;
            r_cpu_dout   <= 8'd0;
            r_cpu_ack    <= 1'b0;
            r_mem_addr   <= 17'd0;
            r_mem_dout   <= 8'd0;
            r_mem_oe     <= 1'b0;
            r_mem_we     <= 1'b0;
        end else begin
            r_phase      <= w_phase_n;
            r_started    <= w_started_n;
            r_pending    <= w_pending_n;
            r_cpu_act    <= w_cpu_act_n;
            r_video_data <= w_video_data_n;
            r_ram_stb    <= w_ram_stb_n;
            r_rom_stb    <= w_rom_stb_n;
            r_cpu_dout   <= w_cpu_dout_n;
            r_cpu_ack    <= w_cpu_ack_n;
            r_mem_addr   <= w_mem_addr_n;
            r_mem_dout   <= w_mem_dout_n;
            r_mem_oe     <= w_mem_oe_n;
            r_mem_we     <= w_mem_we_n;
        end
    end

    assign video_data       = r_video_data;
    assign video_ram_strobe = r_ram_stb;
    assign video_rom_strobe = r_rom_stb;
    assign cpu_dout         = r_cpu_dout;
    assign cpu_ack          = r_cpu_ack;
    assign mem_addr         = r_mem_addr;
    assign mem_dout         = r_mem_dout;
    assign mem_oe           = r_mem_oe;
    assign mem_we           = r_mem_we;

endmodule

// File: tb/tb_video_mem_sequencer.sv
// Scoreboard bench for video_mem_sequencer: stimulus pushes expected fetches/writes/acks, a monitor pops on each DUT event.
module tb_video_mem_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        char_clk;
    logic [11:0] video_addr;
    logic [7:0]  video_data;
    logic        video_ram_strobe;
    logic        video_rom_strobe;
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic [16:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_oe;
    logic        mem_we;

    video_mem_sequencer dut (
        .clk(clk), .reset_n(reset_n), .char_clk(char_clk),
        .video_addr(video_addr), .video_data(video_data),
        .video_ram_strobe(video_ram_strobe), .video_rom_strobe(video_rom_strobe),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_oe(mem_oe), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    // SRAM contents seen by the sequencer; reads return a marker when not output-enabled.
    function automatic logic [7:0] sram_model(input logic [16:0] a);
        case (a)
            17'h08005: sram_model = 8'h41;
            17'h08123: sram_model = 8'h9A;
            17'h087FF: sram_model = 8'hC3;
            17'h1000A: sram_model = 8'h3C;
            17'h107FF: sram_model = 8'h81;
            17'h10000: sram_model = 8'h7E;
            17'h08200: sram_model = 8'hA5;
            default:   sram_model = a[7:0] ^ 8'h5A;
        endcase
    endfunction
    assign mem_din = mem_oe ? sram_model(mem_addr) : 8'hEE;

    logic [2:0] tb_phase;
    always @(posedge clk) begin
        if (!reset_n || char_clk) tb_phase <= 3'd0;
        else                      tb_phase <= tb_phase + 3'd1;
    end

    int n_checks = 0;
    int n_pass = 0;
    int n_ram_seen = 0;
    logic [24:0] ram_q[$];
    logic [24:0] rom_q[$];
    logic [24:0] wr_q[$];
    logic [8:0]  ack_q[$];

    logic [11:0] ram_va [3]  = '{12'h005, 12'h123, 12'h7FF};
    logic [24:0] ram_exp [3] = '{{17'h08005, 8'h41}, {17'h08123, 8'h9A}, {17'h087FF, 8'hC3}};
    logic [11:0] rom_va [3]  = '{12'h80A, 12'hFFF, 12'h800};
    logic [24:0] rom_exp [3] = '{{17'h1000A, 8'h3C}, {17'h107FF, 8'h81}, {17'h10000, 8'h7E}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [2:0] p);
        int n = 0;
        while (tb_phase != p && n < 20) begin
            tick();
            n++;
        end
        if (tb_phase != p) begin
            n_checks++;
            $display("FAIL wait_phase: phase %0d not reached, at %0d", p, tb_phase);
        end
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!cpu_ack && lat < 30);
        if (!cpu_ack) begin
            n_checks++;
            $display("FAIL ack_timeout: no cpu_ack within %0d cycles", lat);
        end
    endtask

    // Video-side stimulus: address for each ROM fetch set in phase 2, next RAM fetch in phase 5.
    initial begin
        int ri = 1;
        int oi = 0;
        video_addr = ram_va[0];
        ram_q.push_back(ram_exp[0]);
        forever begin
            tick();
            if (reset_n && tb_phase == 3'd2) begin
                video_addr = rom_va[oi % 3];
                rom_q.push_back(rom_exp[oi % 3]);
                oi++;
            end else if (reset_n && tb_phase == 3'd5) begin
                video_addr = ram_va[ri % 3];
                ram_q.push_back(ram_exp[ri % 3]);
                ri++;
            end
        end
    end

    initial begin
        logic [24:0] e;
        logic [8:0]  a;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (video_ram_strobe || video_rom_strobe || mem_we)
                    check("no_overlap", {30'd0, video_ram_strobe & video_rom_strobe,
                                         (video_ram_strobe | video_rom_strobe) & mem_we}, 32'd0);
                if (video_ram_strobe) begin
                    n_ram_seen++;
                    if (ram_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL ram_strobe: unexpected strobe addr 0x%0h", mem_addr);
                    end else begin
                        e = ram_q.pop_front();
                        check("ram_fetch", {7'd0, mem_addr, video_data}, {7'd0, e});
                        check("ram_phase", {29'd0, tb_phase}, 32'd1);
                    end
                end
                if (video_rom_strobe) begin
                    if (rom_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL rom_strobe: unexpected strobe addr 0x%0h", mem_addr);
                    end else begin
                        e = rom_q.pop_front();
                        check("rom_fetch", {7'd0, mem_addr, video_data}, {7'd0, e});
                        check("rom_phase", {29'd0, tb_phase}, 32'd4);
                    end
                end
                if (mem_we) begin
                    if (wr_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL mem_we: unexpected write addr 0x%0h data 0x%0h", mem_addr, mem_dout);
                    end else begin
                        e = wr_q.pop_front();
                        check("cpu_write", {7'd0, mem_addr, mem_dout}, {7'd0, e});
                        check("write_phase", {29'd0, tb_phase}, 32'd6);
                    end
                end
                if (cpu_ack) begin
                    if (ack_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL cpu_ack: unexpected ack");
                    end else begin
                        a = ack_q.pop_front();
                        check("ack_phase", {29'd0, tb_phase}, 32'd7);
                        if (a[8]) check("cpu_dout", {24'd0, cpu_dout}, {24'd0, a[7:0]});
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int lat2;
        reset_n  = 1'b0;
        char_clk = 1'b1;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 17'd0;
        cpu_din  = 8'd0;
        repeat (3) tick();
        check("rst_video", {22'd0, video_data, video_ram_strobe, video_rom_strobe}, 32'd0);
        check("rst_cpu", {23'd0, cpu_dout, cpu_ack}, 32'd0);
        check("rst_mem", {5'd0, mem_addr, mem_dout, mem_oe, mem_we}, 32'd0);
        #3 reset_n = 1'b1;
        repeat (5) tick();
        check("held_phase0_addr", {14'd0, mem_addr, mem_oe}, {14'd0, 17'h08005, 1'b1});
        char_clk = 1'b0;

        // CPU write raised in phase 2
        wait_phase(3'd2);
        wr_q.push_back({17'h08010, 8'h55});
        ack_q.push_back({1'b0, 8'h00});
        cpu_we = 1'b1; cpu_addr = 17'h08010; cpu_din = 8'h55; cpu_req = 1'b1;
        wait_ack(lat);
        check("wr_latency", lat, 32'd5);
        cpu_req = 1'b0;

        // CPU read raised in phase 7
        wait_phase(3'd0);
        wait_phase(3'd7);
        ack_q.push_back({1'b1, 8'hA5});
        cpu_we = 1'b0; cpu_addr = 17'h08200; cpu_req = 1'b1;
        wait_ack(lat);
        check("rd_latency", lat, 32'd8);
        check("rd_dout_direct", {24'd0, cpu_dout}, 32'h000000A5);
        cpu_req = 1'b0;

        // Resync abort during the CPU slot
        wait_phase(3'd5);
        wr_q.push_back({17'h08030, 8'h66});
        wr_q.push_back({17'h08030, 8'h66});
        ack_q.push_back({1'b0, 8'h00});
        cpu_we = 1'b1; cpu_addr = 17'h08030; cpu_din = 8'h66; cpu_req = 1'b1;
        tick();
        check("abort_we_before", {31'd0, mem_we}, 32'd1);
        char_clk = 1'b1;
        tick();
        char_clk = 1'b0;
        check("abort_we_ack_after", {30'd0, mem_we, cpu_ack}, 32'd0);
        wait_ack(lat2);
        check("abort_latency", lat2 + 2, 32'd9);
        cpu_req = 1'b0;

        // Write into the character ROM window, then hold req for a back-to-back read
        wait_phase(3'd5);
`ifndef CHAR_ROM_WP_EN
        wr_q.push_back({17'h10003, 8'h77});
`endif
        ack_q.push_back({1'b0, 8'h00});
        cpu_we = 1'b1; cpu_addr = 17'h10003; cpu_din = 8'h77; cpu_req = 1'b1;
        wait_ack(lat);
        check("rom_wr_latency", lat, 32'd2);
        ack_q.push_back({1'b1, 8'h9A});
        cpu_we = 1'b0; cpu_addr = 17'h08123;
        wait_ack(lat);
        check("b2b_latency", lat, 32'd8);
        cpu_req = 1'b0;

        wait_phase(3'd0);
        wait_phase(3'd7);
        check("wr_q_drained", wr_q.size(), 32'd0);
        check("ack_q_drained", ack_q.size(), 32'd0);
        check("ram_fetches_seen", {31'd0, n_ram_seen >= 5}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
